// File: rtl/regfile_write_decoder.sv
// Registered write-enable decoder for the general register file.
// Turns per-port binary write addresses into one-hot strobes, resolves same-target
// collisions by fixed priority (highest port index wins) and keeps a busy bitmap
// that issue sets and writeback clears.
module regfile_write_decoder #(
    parameter int unsigned N         = 5,
    parameter int unsigned NPORTS    = 2,
    parameter int unsigned ZERO_HOLD = 1
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic [NPORTS-1:0]        E,
    input  logic [NPORTS*N-1:0]      D,
    input  logic                     SETE,
    input  logic [N-1:0]             SETD,
    output logic [NPORTS*(1<<N)-1:0] O,
    output logic [(1<<N)-1:0]        WE,
    output logic [NPORTS-1:0]        CONF,
    output logic [(1<<N)-1:0]        BUSY,
    output logic                     HAZ
);

    localparam int unsigned R = 1 << N;

    logic [N-1:0]          addr [NPORTS];
    logic [NPORTS-1:0]     req;
    logic [NPORTS-1:0]     win;
    logic [NPORTS-1:0]     conf_d, conf_q;
    logic [NPORTS*R-1:0]   o_d, o_q;
    logic [R-1:0]          we_d, we_q;
    logic [R-1:0]          set_vec;
    logic [R-1:0]          busy_d, busy_q;

    // Unpack addresses and qualify requests; hardwired register 0 requests vanish.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            addr[p] = D[p*N +: N];
            req[p]  = E[p] && !((ZERO_HOLD != 0) && (addr[p] == '0));
        end
    end

    // A request wins unless a higher-index request targets the same register.
    always_comb begin
        win = req;
        for (int p = 0; p < NPORTS; p++) begin
            for (int q = 0; q < NPORTS; q++) begin
                if ((q > p) && req[q] && (addr[q] == addr[p])) begin
                    win[p] = 1'b0;
                end
            end
        end
        conf_d = req & ~win;
    end

    // One-hot strobe per winning port and the merged register-file write enable.
    always_comb begin
        o_d  = '0;
        we_d = '0;
        for (int p = 0; p < NPORTS; p++) begin
            for (int r = 0; r < R; r++) begin
                o_d[p*R + r] = win[p] && (addr[p] == r[N-1:0]);
            end
            we_d = we_d | o_d[p*R +: R];
        end
    end

    // Busy next state: issue set beats a same-cycle writeback clear.
    always_comb begin
        set_vec = '0;
        for (int r = 0; r < R; r++) begin
            set_vec[r] = SETE && (SETD == r[N-1:0]) && !((ZERO_HOLD != 0) && (r == 0));
        end
        busy_d = set_vec | (busy_q & ~we_d);
    end

    // Output and busy registers; reset drops any pending strobes and busy bits.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            o_q    <= '0;
            we_q   <= '0;
            conf_q <= '0;
            busy_q <= '0;
        end else begin
            o_q    <= o_d;
            we_q   <= we_d;
            conf_q <= conf_d;
            busy_q <= busy_d;
        end
    end

    assign O    = o_q;
    assign WE   = we_q;
    assign CONF = conf_q;
    assign BUSY = busy_q;

    // WAW hazard view for issue: only edges already committed to BUSY are visible.
    assign HAZ = SETE && busy_q[SETD];

endmodule
